// File: rtl/pcs_tx_am_gbx.sv
// Multi-lane PCS TX back-end: alignment-marker insertion, idle fill and 66b->64b gearbox.
// One shared slot sequencer; each lane owns its own gearbox residue.

module pcs_tx_am_gbx_lane #(
  parameter int DATA_W = 64,
  parameter int HEAD_W = 2,
  parameter int SEQ_W  = 6
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [SEQ_W-1:0]         seq_q,
  input  logic [DATA_W+HEAD_W-1:0] blk,
  output logic [DATA_W-1:0]        data_o
);
  localparam int CAT_W = 2*DATA_W;
  localparam logic [SEQ_W-1:0] SEQ_PAUSE = SEQ_W'(DATA_W/HEAD_W);

  logic [DATA_W-1:0] res_q;
  logic [CAT_W-1:0]  cat;

  // Residue holds HEAD_W*seq_q bits at the bottom; the new block lands right above it.
  assign cat = {{DATA_W{1'b0}}, res_q}
             | ({{(CAT_W-DATA_W-HEAD_W){1'b0}}, blk} << (int'(seq_q) * HEAD_W));

  always_ff @(posedge clk) begin
    if (!nreset) begin
      res_q  <= '0;
      data_o <= '0;
    end else if (seq_q == SEQ_PAUSE) begin
      data_o <= res_q;
      res_q  <= '0;
    end else begin
      data_o <= cat[DATA_W-1:0];
      res_q  <= cat[CAT_W-1:DATA_W];
    end
  end
endmodule

module pcs_tx_am_gbx #(
  parameter int LANE_N    = 4,
  parameter int DATA_W    = 64,
  parameter int HEAD_W    = 2,
  parameter int AM_PERIOD = 16383,
  parameter int AM_CNT_W  = $clog2(AM_PERIOD+1),
  parameter int SEQ_W     = 6
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     valid_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  input  logic [LANE_N*DATA_W-1:0] am_i,
  output logic                     ready_o,
  output logic                     am_v_o,
  output logic                     underflow_o,
  output logic [LANE_N*DATA_W-1:0] data_o
);
  localparam bit                  AM_EN     = LANE_N > 1;
  localparam logic [SEQ_W-1:0]    SEQ_PAUSE = SEQ_W'(DATA_W/HEAD_W);
  localparam logic [HEAD_W-1:0]   HEAD_CTL  = HEAD_W'(2'b10);
  localparam logic [DATA_W-1:0]   IDLE_BLK  = DATA_W'(64'h1E);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [HEAD_W-1:0] head;
  } blk_t;

  logic [SEQ_W-1:0]    seq_q;
  logic [AM_CNT_W-1:0] am_cnt_q;
  logic                pause, am_slot, dat_slot;
  blk_t [LANE_N-1:0]   blk;

  // Pause outranks a due marker, which then simply waits one cycle.
  assign pause    = seq_q == SEQ_PAUSE;
  assign am_slot  = AM_EN && !pause && (am_cnt_q == AM_CNT_W'(AM_PERIOD));
  assign dat_slot = !pause && !am_slot;

  assign ready_o     = nreset & dat_slot;
  assign am_v_o      = nreset & am_slot;
  assign underflow_o = ready_o & ~valid_i;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      seq_q    <= '0;
      am_cnt_q <= '0;
    end else begin
      seq_q <= pause ? '0 : seq_q + SEQ_W'(1);
      if (am_slot)
        am_cnt_q <= '0;
      else if (dat_slot && AM_EN)
        am_cnt_q <= am_cnt_q + AM_CNT_W'(1);
    end
  end

  always_comb begin
    for (int l = 0; l < LANE_N; l++) begin
      blk[l].head = HEAD_CTL;
      blk[l].data = IDLE_BLK;
      if (am_slot) begin
        blk[l].data = am_i[l*DATA_W +: DATA_W];
      end else if (valid_i) begin
        blk[l].head = head_i[l*HEAD_W +: HEAD_W];
        blk[l].data = data_i[l*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    pcs_tx_am_gbx_lane #(.DATA_W(DATA_W), .HEAD_W(HEAD_W), .SEQ_W(SEQ_W)) u_lane (
      .clk    (clk),
      .nreset (nreset),
      .seq_q  (seq_q),
      .blk    (blk[l]),
      .data_o (data_o[l*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_pcs_tx_am_gbx.sv
// Bench for pcs_tx_am_gbx: 4-lane marker instance and 1-lane packing instance side by side,
// checked against a bit-queue serial-stream model plus a constant packing table.
module tb_pcs_tx_am_gbx;
  localparam int P4 = 4;
  localparam int P1 = 16383;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nreset, valid;
  logic [7:0]   head4;
  logic [255:0] data4, am4, out4;
  logic [1:0]   head1;
  logic [63:0]  data1, am1, out1;
  logic         ready4, amv4, uf4, ready1, amv1, uf1;

  pcs_tx_am_gbx #(.LANE_N(4), .AM_PERIOD(P4)) u_dut4 (
    .clk(clk), .nreset(nreset), .valid_i(valid), .head_i(head4), .data_i(data4),
    .am_i(am4), .ready_o(ready4), .am_v_o(amv4), .underflow_o(uf4), .data_o(out4));

  pcs_tx_am_gbx #(.LANE_N(1), .AM_PERIOD(P1)) u_dut1 (
    .clk(clk), .nreset(nreset), .valid_i(valid), .head_i(head1), .data_i(data1),
    .am_i(am1), .ready_o(ready1), .am_v_o(amv1), .underflow_o(uf1), .data_o(out1));

  int total = 0;
  int bad   = 0;

  // Reference model: per-DUT cycle/block counters, per-lane serial bit queue (index d*4+lane).
  int          mcyc[2];
  int          mblk[2];
  bit          mq[8][$];
  logic [63:0] exp_out[2][4];

  bit          prev_stall4 = 1'b0;
  int          coll = 0;
  int          uf_seen = 0;
  logic [63:0] obs1;
  bit          obs_rdy1, obs_rdy4, obs_amv4;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  head;
    bit          exp_ready;
    logic [63:0] exp_out;
  } vec_t;
  vec_t tbl[33];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_blk(input int qi, input logic [1:0] hd, input logic [63:0] dt);
    for (int i = 0; i < 2; i++) mq[qi].push_back(hd[i]);
    for (int i = 0; i < 64; i++) mq[qi].push_back(dt[i]);
  endtask

  task automatic model_step(input int d, input int n, input int p, input bit v,
                            input logic [255:0] dat, input logic [7:0] hd, input logic [255:0] am,
                            output bit e_rdy, output bit e_amv, output bit e_uf);
    bit pause, mk;
    if (!nreset) begin
      e_rdy = 0; e_amv = 0; e_uf = 0;
      mcyc[d] = 0; mblk[d] = 0;
      for (int l = 0; l < 4; l++) begin
        mq[d*4+l].delete();
        exp_out[d][l] = '0;
      end
      return;
    end
    pause = (mcyc[d] == 32);
    mk    = !pause && (n > 1) && (mblk[d] == p);
    e_rdy = !pause && !mk;
    e_amv = mk;
    e_uf  = e_rdy && !v;
    for (int l = 0; l < n; l++) begin
      if (mk)
        push_blk(d*4+l, 2'b10, am[l*64 +: 64]);
      else if (e_rdy)
        push_blk(d*4+l, v ? hd[l*2 +: 2] : 2'b10, v ? dat[l*64 +: 64] : 64'h1E);
      for (int i = 0; i < 64; i++)
        exp_out[d][l][i] = (mq[d*4+l].size() > 0) ? mq[d*4+l].pop_front() : 1'b0;
    end
    if (mk) mblk[d] = 0;
    else if (e_rdy) mblk[d] = mblk[d] + 1;
    mcyc[d] = (mcyc[d] + 1) % 33;
  endtask

  // Entered at a negedge, returns at the next negedge.
  task automatic cyc(input bit v, input logic [63:0] d1, input logic [1:0] h1);
    bit r4, a4, u4, r1, a1, u1;
    valid = v; data1 = d1; head1 = h1;
    for (int l = 0; l < 4; l++) begin
      data4[l*64 +: 64] = {$urandom, $urandom};
      head4[l*2 +: 2]   = 2'($urandom);
    end
    #1;
    model_step(0, 4, P4, v, data4, head4, am4, r4, a4, u4);
    model_step(1, 1, P1, v, {192'b0, data1}, {6'b0, head1}, 256'b0, r1, a1, u1);
    chk("ready4", ready4, r4);
    chk("am_v4", amv4, a4);
    chk("underflow4", uf4, u4);
    chk("ready1", ready1, r1);
    chk("am_v1", amv1, a1);
    chk("underflow1", uf1, u1);
    if (nreset && !ready4 && amv4 && prev_stall4) coll++;
    prev_stall4 = nreset && !ready4;
    if (uf4) uf_seen++;
    obs_rdy1 = ready1; obs_rdy4 = ready4; obs_amv4 = amv4;
    @(posedge clk); #1;
    for (int l = 0; l < 4; l++)
      chk($sformatf("out4_lane%0d", l), out4[l*64 +: 64], exp_out[0][l]);
    chk("out1", out1, exp_out[1][0]);
    obs1 = out1;
    @(negedge clk);
  endtask

  task automatic run_table();
    for (int k = 0; k < 33; k++) begin
      cyc(1'b1, tbl[k].data, tbl[k].head);
      chk($sformatf("tbl_ready_%0d", k), obs_rdy1, tbl[k].exp_ready);
      chk($sformatf("tbl_out_%0d", k), obs1, tbl[k].exp_out);
    end
  endtask

  initial begin
    int budget, acc;
    // Block k carries head 2'b01 and payload k; output k is bits [64k, 64k+63] of the stream.
    for (int k = 0; k < 32; k++) begin
      tbl[k].data      = 64'(k);
      tbl[k].head      = 2'b01;
      tbl[k].exp_ready = 1'b1;
      tbl[k].exp_out   = (64'(1) << (2*k)) | (64'(k) << (2*k+2));
      if (k > 0) tbl[k].exp_out = tbl[k].exp_out | (64'(k-1) >> (64-2*k));
    end
    tbl[32].data = 64'hDEAD; tbl[32].head = 2'b01;
    tbl[32].exp_ready = 1'b0; tbl[32].exp_out = 64'd31;

    nreset = 1'b0; valid = 1'b1;
    am4 = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    am1 = 64'hFF; data1 = '0; head1 = '0; data4 = '0; head4 = '0;
    @(negedge clk);
    repeat (3) cyc(1'b1, 64'h5, 2'b01);
    chk("rst_out1", out1, 64'h0);
    chk("rst_out4", out4[63:0], 64'h0);
    chk("rst_ready4", ready4, 1'b0);

    nreset = 1'b1;
    run_table();

    repeat (300) cyc($urandom_range(0, 9) != 0, {$urandom, $urandom}, 2'($urandom));
    chk("collision_seen", coll > 0, 1'b1);

    // Underflow: two idle data slots right after a marker, then count blocks to the next marker.
    budget = 0;
    while (!(mblk[0] == 0 && mcyc[0] > 0 && mcyc[0] < 28) && budget < 100) begin
      cyc(1'b1, {$urandom, $urandom}, 2'b01);
      budget++;
    end
    chk("uf_wait", budget < 100, 1'b1);
    uf_seen = 0;
    cyc(1'b0, 64'h0, 2'b01);
    cyc(1'b0, 64'h0, 2'b01);
    chk("uf_pulses", 64'(uf_seen), 64'd2);
    acc = 0; budget = 0;
    obs_amv4 = 1'b0;
    while (!obs_amv4 && budget < 40) begin
      cyc(1'b1, {$urandom, $urandom}, 2'b01);
      if (obs_rdy4) acc++;
      budget++;
    end
    chk("uf_marker_seen", obs_amv4, 1'b1);
    chk("uf_blocks_to_marker", 64'(acc), 64'd2);

    // Mid-stream reset at seq 17, then the packing table must reappear block-aligned.
    budget = 0;
    while (mcyc[0] != 17 && budget < 100) begin
      cyc(1'b1, {$urandom, $urandom}, 2'($urandom));
      budget++;
    end
    chk("seq17_wait", budget < 100, 1'b1);
    nreset = 1'b0;
    cyc(1'b1, 64'h77, 2'b01);
    chk("midrst_out1", obs1, 64'h0);
    nreset = 1'b1;
    run_table();

    repeat (200) cyc(1'b1, {$urandom, $urandom}, 2'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pcs_tx_am_gbx.md
# pcs_tx_am_gbx

Parametrised multi-lane PCS transmit back-end: sits after the 64b/66b encoder and scrambler and in front of the PMA. It merges per-lane 66b blocks with periodic, runtime-programmable alignment markers, fills empty slots with idle blocks, and packs the 66b stream of each lane into 64b PMA words through a shared 33-cycle gearbox sequence. One `ready_o` backpressures the MAC/scrambler path for both marker slots and gearbox pause cycles. Unlike the fixed 4-lane/10G split design, lane count, marker period and marker contents are all generic.

## Interface
- `LANE_N`, 4: number of PCS lanes. Legal range 1..20; 1 disables marker insertion.
- `DATA_W`, 64: block payload width. Fixed at 64.
- `HEAD_W`, 2: sync header width. Fixed at 2.
- `AM_PERIOD`, 16383: data blocks per lane between two markers. Must be ≥ 2.
- `AM_CNT_W`, `$clog2(AM_PERIOD+1)`: marker counter width. Derived.
- `SEQ_W`, 6: gearbox sequence counter width. Derived.

Ports:
- `clk`  in  1  clock.
- `nreset`  in  1  synchronous reset, active low.
- `valid_i`  in  1  all lanes carry a block this cycle.
- `head_i`  in  LANE_N*HEAD_W  per-lane sync header, lane l at [l*2+1:l*2].
- `data_i`  in  LANE_N*DATA_W  per-lane scrambled payload.
- `am_i`  in  LANE_N*DATA_W  per-lane marker payload. Static; sampled at the marker slot.
- `ready_o`  out  1  a block is accepted when `valid_i & ready_o`.
- `am_v_o`  out  1  the block entering the gearbox this cycle is a marker.
- `underflow_o`  out  1  pulse: an idle block was substituted this cycle.
- `data_o`  out  LANE_N*DATA_W  per-lane PMA word, registered.

## Operation
**Slots.** Each cycle is exactly one of three kinds:
- **Pause:** `seq_q`==32.
- **Marker slot:** `seq_q`!=32 and `am_cnt_q`==AM_PERIOD and `LANE_N`>1.
- **Data slot:** otherwise.

`ready_o` = data slot. It is combinational from internal state only and never depends on `valid_i`.

**Data slot.**
- `valid_i`=1: the block {data_i, head_i} per lane enters the gearbox.
- `valid_i`=0: every lane gets an idle block: head 2'b10, payload 64'h1E (type 0x1E, all other bits 0). `underflow_o`=1.
- Either way `am_cnt_q` increments.

**Marker slot.**
- Each lane gets {am_i lane, head 2'b10}.
- `am_v_o`=1 and `am_cnt_q` is cleared to 0.
- A marker never replaces input data. Input stalls via `ready_o`=0.

**Pause cycle.**
- No block enters and `am_cnt_q` holds.
- If a marker is due on a pause cycle, it is issued in the next cycle, which is a marker slot.

**Gearbox, per lane.**
- Serial stream = concatenation of blocks, each transmitted head bit 0 first, then head bit 1, then data bit 0..63.
- `data_o` bit 0 is the earliest bit.
- `seq_q` counts 0..32 then wraps to 0; it advances every cycle.
- At `seq_q`=s<32 the residue holds 2*s bits. The residue plus the new 66b block yields 64 output bits, and 2*(s+1) bits remain.
- At s=32 the 64-bit residue is emitted and the residue becomes empty.
- All lanes share `seq_q`.

## Timing
- **Reset** (`nreset`=0 at a posedge): `seq_q`=0, `am_cnt_q`=0, residue=0, `data_o`=0, `am_v_o`=0, `underflow_o`=0. While reset is asserted, `ready_o`=0.
- **Reset mid-stream:** the residue is discarded with no flush, and the next output starts block-aligned.
- **First cycle after release:** data slot, `ready_o`=1.
- **Latency:** bits of a block accepted at cycle t first appear in `data_o` at t+1. `am_v_o` and `underflow_o` are combinational, valid in the slot cycle.
- **Throughput:** 32 blocks per 33 cycles.
- **Marker cadence:** exactly AM_PERIOD data/idle blocks between consecutive markers. The first marker follows the first AM_PERIOD blocks after reset.
- **Simultaneous events:** pause and marker-due both true → pause wins and the marker is deferred one cycle. No two adjacent stall cycles occur except this pause+marker pair.
- **Counter wrap:** `seq_q` and `am_cnt_q` never exceed 32 and AM_PERIOD respectively.

## Test plan
- **Reset and ready:** hold `nreset`=0 for 3 cycles with `valid_i`=1 → `data_o`=0 and `ready_o`=0. Release → `ready_o`=1 in the first cycle, and the gearbox stalls only at `seq_q`=32.
- **Gearbox packing**, LANE_N=1, AM disabled: 32 blocks with head 2'b01 and data = block index, `valid_i`=1 throughout → over 33 cycles `data_o` reproduces the serial stream bit-exact. Cycle 1 output = {data0[61:0], 2'b01}. `ready_o`=0 only on cycle 32.
- **Marker insertion**, LANE_N=4, AM_PERIOD=4, am_i lanes = 64'hA0..A3 → after every 4 accepted blocks, one cycle with `ready_o`=0 and `am_v_o`=1, and each lane emits its marker with head 2'b10. Continuous run: the marker pattern repeats every 5 slots.
- **Pause/marker collision:** configure AM_PERIOD so the marker falls due at `seq_q`=32 → two consecutive stall cycles (pause, then marker), after which the block count resumes at 0.
- **Underflow:** drop `valid_i` for 2 data slots → `underflow_o` pulses twice, both lanes carry head 2'b10 / 64'h1E, and the next marker still arrives after exactly AM_PERIOD blocks.
- **Mid-stream reset:** assert `nreset` at `seq_q`=17 → the next output after release is block-aligned and both counters restart at 0.
